// File: rtl/decode_stage.sv
// decode_stage: registered N-lane RV32I decode stage with valid/ready handshake,
// flush, and an intra-bundle RAW-hazard splitter that issues a dependent
// bundle over several output beats.
//
// Optional feature: define DECODE_PERF_EN to add the split_cnt_o and
// invalid_cnt_o performance counters. The default build has neither the
// counter logic nor the extra ports.
//
// Control word encoding (one bit per class, CTRL_W >= 8):
//   LUI=0x01 AUIPC=0x02 JAL=0x04 JALR=0x08 BRANCH=0x10 ALUI=0x20 ALUR=0x40
//   INVALID_INST=0x80, and 0 for an empty (unfetched) slot.
module decode_stage #(
    parameter int LANES  = 2,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [32*LANES-1:0]     inst_i,
    input  logic [LANES-1:0]        fetched_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    flush_i,
    output logic [32*LANES-1:0]     inst_o,
    output logic [CTRL_W*LANES-1:0] ctrl_o,
    output logic [LANES-1:0]        lane_valid_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    trap_o
`ifdef DECODE_PERF_EN
    ,
    output logic [CNT_W-1:0]        split_cnt_o,
    output logic [CNT_W-1:0]        invalid_cnt_o
`endif
);

    // Parameter sanity: this block is empty and only elaborates for illegal
    // settings, giving tools a named scope to flag.
    if (LANES < 1 || LANES > 4 || CTRL_W < 8 || CNT_W < 1) begin : g_bad_params
    end

    localparam logic [CTRL_W-1:0] LUI_CTRL          = CTRL_W'(8'h01);
    localparam logic [CTRL_W-1:0] AUIPC_CTRL        = CTRL_W'(8'h02);
    localparam logic [CTRL_W-1:0] JAL_CTRL          = CTRL_W'(8'h04);
    localparam logic [CTRL_W-1:0] JALR_CTRL         = CTRL_W'(8'h08);
    localparam logic [CTRL_W-1:0] BRANCH_CTRL       = CTRL_W'(8'h10);
    localparam logic [CTRL_W-1:0] ALUI_CTRL         = CTRL_W'(8'h20);
    localparam logic [CTRL_W-1:0] ALUR_CTRL         = CTRL_W'(8'h40);
    localparam logic [CTRL_W-1:0] INVALID_INST_CTRL = CTRL_W'(8'h80);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_SPLIT
    } state_t;

    // Classify one instruction from its opcode/funct fields.
    function automatic logic [CTRL_W-1:0] decode_lane(
        input logic [6:0] opcode,
        input logic [2:0] funct3,
        input logic [6:0] funct7,
        input logic       fetched
    );
        logic [CTRL_W-1:0] ctrl;
        ctrl = INVALID_INST_CTRL;
        if (!fetched) begin
            ctrl = '0;
        end else begin
            case (opcode)
                OP_LUI:    ctrl = LUI_CTRL;
                OP_AUIPC:  ctrl = AUIPC_CTRL;
                OP_JAL:    ctrl = JAL_CTRL;
                OP_JALR:   if (funct3 == 3'b000) ctrl = JALR_CTRL;
                OP_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) ctrl = BRANCH_CTRL;
                OP_ALUI: begin
                    case (funct3)
                        3'b001:  if (funct7 == 7'h00) ctrl = ALUI_CTRL;
                        3'b101:  if (funct7 == 7'h00 || funct7 == 7'h20) ctrl = ALUI_CTRL;
                        default: ctrl = ALUI_CTRL;
                    endcase
                end
                OP_ALUR: begin
                    if (funct7 == 7'h00 ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                        ctrl = ALUR_CTRL;
                end
                default: ctrl = INVALID_INST_CTRL;
            endcase
        end
        return ctrl;
    endfunction

    state_t                    state_q, state_d;
    logic [LANES-1:0]          pending_q, pending_d;
    logic [32*LANES-1:0]       inst_q, inst_d;
    logic [CTRL_W*LANES-1:0]   ctrl_q, ctrl_d;

    logic [CTRL_W*LANES-1:0]   ctrl_in;
    logic [LANES-1:0]          pending_in;
    logic [LANES-1:0]          writes_rd, reads_rs1, reads_rs2, invalid_lane, hazard;
    logic [LANES-1:0][4:0]     rd, rs1, rs2;
    logic [LANES-1:0]          beat, remaining;
    logic                      accept;

    // Decode incoming bundle; the pending mask stops after the oldest invalid lane.
    always_comb begin
        logic seen_invalid;
        ctrl_in      = '0;
        pending_in   = '0;
        seen_invalid = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            ctrl_in[l*CTRL_W +: CTRL_W] = decode_lane(inst_i[32*l +: 7],
                                                      inst_i[32*l+12 +: 3],
                                                      inst_i[32*l+25 +: 7],
                                                      fetched_i[l]);
            pending_in[l] = fetched_i[l] && !seen_invalid;
            if (fetched_i[l] && ctrl_in[l*CTRL_W +: CTRL_W] == INVALID_INST_CTRL)
                seen_invalid = 1'b1;
        end
    end

    // Register-usage attributes of each held lane, taken from its control class.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            logic [CTRL_W-1:0] c;
            c               = ctrl_q[l*CTRL_W +: CTRL_W];
            rd[l]           = inst_q[32*l+7  +: 5];
            rs1[l]          = inst_q[32*l+15 +: 5];
            rs2[l]          = inst_q[32*l+20 +: 5];
            writes_rd[l]    = (c == LUI_CTRL) || (c == AUIPC_CTRL) || (c == JAL_CTRL) ||
                              (c == JALR_CTRL) || (c == ALUI_CTRL) || (c == ALUR_CTRL);
            reads_rs1[l]    = (c == JALR_CTRL) || (c == BRANCH_CTRL) ||
                              (c == ALUI_CTRL) || (c == ALUR_CTRL);
            reads_rs2[l]    = (c == BRANCH_CTRL) || (c == ALUR_CTRL);
            invalid_lane[l] = (c == INVALID_INST_CTRL);
        end
    end

    // Beat selection: issue pending lanes below the oldest lane that reads a
    // register written by an older still-pending lane of the same bundle.
    always_comb begin
        logic blocked;
        hazard  = '0;
        beat    = '0;
        blocked = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < k; j++) begin
                if (pending_q[j] && pending_q[k] && writes_rd[j] && rd[j] != 5'd0 &&
                    ((reads_rs1[k] && rs1[k] == rd[j]) || (reads_rs2[k] && rs2[k] == rd[j])))
                    hazard[k] = 1'b1;
            end
            if (hazard[k]) blocked = 1'b1;
            beat[k] = pending_q[k] && !blocked;
        end
        remaining = pending_q & ~beat;
    end

    assign valid_o      = (state_q != S_EMPTY);
    assign lane_valid_o = beat;
    assign trap_o       = valid_o && |(beat & invalid_lane);
    assign ready_o      = !valid_o || (ready_i && remaining == '0);
    assign accept       = valid_i && ready_o;
    assign inst_o       = inst_q;
    assign ctrl_o       = ctrl_q;

    // Next-state logic: flush beats accept, accept beats split/drain.
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        inst_d    = inst_q;
        ctrl_d    = ctrl_q;
        if (flush_i) begin
            state_d   = S_EMPTY;
            pending_d = '0;
        end else if (accept) begin
            state_d   = S_FULL;
            pending_d = pending_in;
            inst_d    = inst_i;
            ctrl_d    = ctrl_in;
        end else if (valid_o && ready_i) begin
            if (remaining != '0) begin
                state_d   = S_SPLIT;
                pending_d = remaining;
            end else begin
                state_d   = S_EMPTY;
                pending_d = '0;
            end
        end
    end

    // State and bundle registers with asynchronous reset.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_EMPTY;
            pending_q <= '0;
            inst_q    <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            inst_q    <= inst_d;
            ctrl_q    <= ctrl_d;
        end
    end

`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0] split_cnt_q, split_cnt_d;
    logic [CNT_W-1:0] invalid_cnt_q, invalid_cnt_d;

    // Counter increments; flush does not touch them, they wrap naturally.
    always_comb begin
        split_cnt_d   = split_cnt_q;
        invalid_cnt_d = invalid_cnt_q;
        if (state_q == S_SPLIT && ready_i)
            split_cnt_d = split_cnt_q + CNT_W'(1);
        if (valid_o && ready_i && trap_o)
            invalid_cnt_d = invalid_cnt_q + CNT_W'(1);
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            split_cnt_q   <= '0;
            invalid_cnt_q <= '0;
        end else begin
            split_cnt_q   <= split_cnt_d;
            invalid_cnt_q <= invalid_cnt_d;
        end
    end

    assign split_cnt_o   = split_cnt_q;
    assign invalid_cnt_o = invalid_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (LANES=2).
// Perf-counter checks are compiled only when DECODE_PERF_EN is defined.
module tb_decode_stage;

    localparam int LANES  = 2;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 32;

    localparam logic [7:0] ALUI    = 8'h20;
    localparam logic [7:0] ALUR    = 8'h40;
    localparam logic [7:0] INVALID = 8'h80;

    localparam logic [31:0] ADDI_X1_5  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] ADD_X2_X1  = 32'h00108133; // add  x2,x1,x1
    localparam logic [31:0] ADDI_X2_3  = 32'h00300113; // addi x2,x0,3
    localparam logic [31:0] ADDI_X0_1  = 32'h00100013; // addi x0,x0,1
    localparam logic [31:0] ADD_X2_X0  = 32'h00000133; // add  x2,x0,x0
    localparam logic [31:0] ALL_ONES   = 32'hFFFFFFFF;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [32*LANES-1:0]     inst_i;
    logic [LANES-1:0]        fetched_i;
    logic                    valid_i;
    logic                    ready_o;
    logic                    flush_i;
    logic [32*LANES-1:0]     inst_o;
    logic [CTRL_W*LANES-1:0] ctrl_o;
    logic [LANES-1:0]        lane_valid_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    trap_o;
`ifdef DECODE_PERF_EN
    logic [CNT_W-1:0]        split_cnt_o;
    logic [CNT_W-1:0]        invalid_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    decode_stage #(.LANES(LANES), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .inst_i       (inst_i),
        .fetched_i    (fetched_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .flush_i      (flush_i),
        .inst_o       (inst_o),
        .ctrl_o       (ctrl_o),
        .lane_valid_o (lane_valid_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .trap_o       (trap_o)
`ifdef DECODE_PERF_EN
        ,
        .split_cnt_o  (split_cnt_o),
        .invalid_cnt_o(invalid_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [31:0] l1, input logic [31:0] l0,
                           input logic [1:0] fetched, input logic valid);
        inst_i    = {l1, l0};
        fetched_i = fetched;
        valid_i   = valid;
    endtask

    initial begin
        rst_i     = 1'b1;
        inst_i    = '0;
        fetched_i = '0;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        ready_i   = 1'b1;

        // Reset state
        #2;
        check("rst_valid",      64'(valid_o),      64'd0);
        check("rst_lane_valid", 64'(lane_valid_o), 64'd0);
        check("rst_ctrl",       64'(ctrl_o),       64'd0);
        check("rst_inst",       64'(inst_o),       64'd0);
        check("rst_trap",       64'(trap_o),       64'd0);
        check("rst_ready",      64'(ready_o),      64'd1);
`ifdef DECODE_PERF_EN
        check("rst_split_cnt",  64'(split_cnt_o),  64'd0);
`endif
        #10 rst_i = 1'b0;
        tick();

        // Dependent pair: split into two beats
        present(ADD_X2_X1, ADDI_X1_5, 2'b11, 1'b1);
        tick();
        present(ADD_X2_X1, ADDI_X1_5, 2'b11, 1'b0);
        check("dep_b1_valid",      64'(valid_o),      64'd1);
        check("dep_b1_lane_valid", 64'(lane_valid_o), 64'b01);
        check("dep_b1_ctrl0",      64'(ctrl_o[7:0]),  64'(ALUI));
        check("dep_b1_ready",      64'(ready_o),      64'd0);
        check("dep_b1_trap",       64'(trap_o),       64'd0);
        tick();
        check("dep_b2_valid",      64'(valid_o),      64'd1);
        check("dep_b2_lane_valid", 64'(lane_valid_o), 64'b10);
        check("dep_b2_ctrl1",      64'(ctrl_o[15:8]), 64'(ALUR));
        check("dep_b2_ready",      64'(ready_o),      64'd1);
        tick();
        check("dep_done_valid",    64'(valid_o),      64'd0);
`ifdef DECODE_PERF_EN
        check("dep_split_cnt",     64'(split_cnt_o),  64'd1);
`endif

        // Independent pair, then x0-destination pair back-to-back
        present(ADDI_X2_3, ADDI_X1_5, 2'b11, 1'b1);
        tick();
        check("ind_lane_valid", 64'(lane_valid_o), 64'b11);
        check("ind_ctrl",       64'(ctrl_o),       64'({ALUI, ALUI}));
        check("ind_ready",      64'(ready_o),      64'd1);
        present(ADD_X2_X0, ADDI_X0_1, 2'b11, 1'b1);
        tick();
        present(ADD_X2_X0, ADDI_X0_1, 2'b11, 1'b0);
        check("x0_inst",        64'(inst_o),       {ADD_X2_X0, ADDI_X0_1});
        check("x0_lane_valid",  64'(lane_valid_o), 64'b11);
        check("x0_ctrl",        64'(ctrl_o),       64'({ALUR, ALUI}));
        check("x0_ready",       64'(ready_o),      64'd1);
        tick();
        check("x0_done_valid",  64'(valid_o),      64'd0);

        // Invalid oldest lane: younger lane dropped
        present(ADDI_X2_3, ALL_ONES, 2'b11, 1'b1);
        tick();
        present(ADDI_X2_3, ALL_ONES, 2'b11, 1'b0);
        check("inv_lane_valid", 64'(lane_valid_o), 64'b01);
        check("inv_ctrl0",      64'(ctrl_o[7:0]),  64'(INVALID));
        check("inv_trap",       64'(trap_o),       64'd1);
        check("inv_ready",      64'(ready_o),      64'd1);
        tick();
        check("inv_done_valid", 64'(valid_o),      64'd0);
        check("inv_lane1_drop", 64'(lane_valid_o), 64'b00);
`ifdef DECODE_PERF_EN
        check("inv_cnt",        64'(invalid_cnt_o), 64'd1);
`endif

        // Nothing fetched: no lane issued, control words zero
        present(ADDI_X2_3, ADDI_X1_5, 2'b00, 1'b1);
        tick();
        present(ADDI_X2_3, ADDI_X1_5, 2'b00, 1'b0);
        check("nofetch_lane_valid", 64'(lane_valid_o), 64'b00);
        check("nofetch_ctrl",       64'(ctrl_o),       64'd0);
        check("nofetch_trap",       64'(trap_o),       64'd0);
        tick();

        // Backpressure: outputs hold for 3 cycles, then drain and accept same cycle
        ready_i = 1'b0;
        present(ADDI_X2_3, ADDI_X1_5, 2'b11, 1'b1);
        tick();
        present(ADD_X2_X0, ADDI_X0_1, 2'b11, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check("bp_inst",       64'(inst_o),       {ADDI_X2_3, ADDI_X1_5});
            check("bp_ctrl",       64'(ctrl_o),       64'({ALUI, ALUI}));
            check("bp_lane_valid", 64'(lane_valid_o), 64'b11);
            check("bp_ready",      64'(ready_o),      64'd0);
            tick();
        end
        ready_i = 1'b1;
        #1;
        check("bp_release_ready", 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0;
        check("bp_next_inst",       64'(inst_o),       {ADD_X2_X0, ADDI_X0_1});
        check("bp_next_lane_valid", 64'(lane_valid_o), 64'b11);
        tick();
        check("bp_done_valid",      64'(valid_o),      64'd0);

        // Flush during split: pending lane 1 lost, concurrent input discarded
        present(ADD_X2_X1, ADDI_X1_5, 2'b11, 1'b1);
        tick();
        valid_i = 1'b0;
        tick();
        check("fl_split_lane_valid", 64'(lane_valid_o), 64'b10);
        ready_i = 1'b0;
        flush_i = 1'b1;
        present(ADDI_X2_3, ADDI_X1_5, 2'b11, 1'b1);
        tick();
        check("fl_valid",      64'(valid_o),      64'd0);
        check("fl_lane_valid", 64'(lane_valid_o), 64'b00);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("fl_discard_valid", 64'(valid_o), 64'd0);
`ifdef DECODE_PERF_EN
        check("fl_split_cnt",     64'(split_cnt_o), 64'd1);
`endif

        // Async reset mid-split: outputs clear before any clock edge
        present(ADD_X2_X1, ADDI_X1_5, 2'b11, 1'b1);
        tick();
        valid_i = 1'b0;
        tick();
        ready_i = 1'b0;
        check("rs_split_lane_valid", 64'(lane_valid_o), 64'b10);
        #2 rst_i = 1'b1;
        #1;
        check("rs_valid",      64'(valid_o),      64'd0);
        check("rs_lane_valid", 64'(lane_valid_o), 64'b00);
        check("rs_ctrl",       64'(ctrl_o),       64'd0);
        check("rs_inst",       64'(inst_o),       64'd0);
        check("rs_trap",       64'(trap_o),       64'd0);
`ifdef DECODE_PERF_EN
        check("rs_split_cnt",  64'(split_cnt_o),  64'd0);
`endif
        #1 rst_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("rs_after_valid", 64'(valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
